rom_arbiter: RTL and testbench
==============================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter AW, default 14, ROM address width.
REQ-002 Parameter DW, default 8, ROM data width.
REQ-003 Parameter RR, default 1: 1 = round-robin, 0 = fixed priority with port 0 winning.
REQ-004 clock  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req0 / req1  in  1  level request per port; held with its address until the port's ack.
REQ-007 addr0 / addr1  in  AW  requested ROM address per port.
REQ-008 ack0 / ack1  out  1  one-cycle pulse: request accepted, address captured.
REQ-009 valid0 / valid1  out  1  one-cycle pulse: read data present on the port's data bus.
REQ-010 data0 / data1  out  DW  per-port read data, held until that port's next valid.
REQ-011 rom_enable  out  1  read enable to the synchronous ROM (1-cycle read latency).
REQ-012 rom_address  out  AW  registered address to the ROM.
REQ-013 rom_q  in  DW  ROM read data, valid the cycle after a rom_enable cycle.
REQ-014 busy  out  1  high whenever state is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE and CAPTURE.
REQ-016 Requests SHALL be sampled only in IDLE; no sampling in ISSUE or CAPTURE.
REQ-017 IDLE with any request active (edge T+1): latch winner's address into rom_address, pulse winner's ack, record winner, go to ISSUE.
REQ-018 ISSUE: rom_enable SHALL be 1, decoded from state, for exactly one cycle; next state CAPTURE.
REQ-019 CAPTURE: rom_q is sampled; at the next edge the winner's data is loaded and its valid pulsed, and the state returns to IDLE.
REQ-020 Latency: request seen in IDLE at cycle T -> ack at T+1, rom_enable at T+1, valid/data at T+3.
REQ-021 Throughput: at most one access per 3 cycles; a request present at T+3 SHALL be acked at T+4.
REQ-022 RR=1, both requests active: grant goes to the port not granted last.
REQ-023 RR=1, single request: grant goes to that port regardless of history.
REQ-024 RR=0: port 0 always wins a tie.
REQ-025 The round-robin pointer SHALL update only on a grant.
REQ-026 rom_enable SHALL be 0 in IDLE and CAPTURE.
REQ-027 rom_address SHALL hold its value outside grants.
REQ-028 ack and valid SHALL never be asserted on both ports in the same cycle.
REQ-029 Address width: rom_address takes addrN verbatim, no arithmetic; an all-ones address is legal.
REQ-030 A requester still holding req after its ack SHALL be treated as a new request at the next IDLE.
REQ-031 The non-winning port's data and valid SHALL remain untouched during an access.

Reset
REQ-032 When reset is high at an edge, the block SHALL go to IDLE with ack0/1, valid0/1 and busy = 0, rom_address = 0, data0/1 = 0, and the pointer set so port 0 wins the first tie.
REQ-033 Reset in ISSUE or CAPTURE SHALL abort the access: no valid is produced for the aborted request.
REQ-034 Reset SHALL take priority over any simultaneous request.

Structure
REQ-035 Shared package rom_arb_pkg SHALL hold the state encoding constants (IDLE, ISSUE, CAPTURE) and the port-index constants.
REQ-036 One sub-module SHALL exist: rom_arb_pick, a combinational 2-way picker taking the requests, the pointer and RR and returning the winner index.
REQ-037 The ROM is instantiated outside this block and connected via rom_enable, rom_address and rom_q.

Verification
REQ-038 Single read: req0=1, addr0=0x0010, ROM[0x10]=0xA5 -> ack0 at T+1, rom_enable at T+1, valid0 and data0=0xA5 at T+3, busy high T+1..T+2.
REQ-039 Tie with RR=1: req0 and req1 both held, addr0=0x0001, addr1=0x0002 -> grants alternate 0,1,0,1; ack spacing 3 cycles; data matches ROM.
REQ-040 Tie with RR=0: both held for 4 accesses -> all four grants to port 0; port 1 starved while req0 stays high.
REQ-041 Boundary address: addr1=0x3FFF, ROM[0x3FFF]=0x5A -> data1=0x5A, valid1 at T+3, data0 unchanged.
REQ-042 Reset mid-access: reset pulsed in CAPTURE -> no valid pulse, all outputs at reset values next cycle, next req1 acked normally.
REQ-043 Back-to-back: req0 held continuously -> ack0 at T+1, T+4, T+7; valid0 at T+3, T+6, T+9; never two acks within 3 cycles.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared constants for the two-port ROM arbiter: FSM state encoding and port indices.
package rom_arb_pkg;

  typedef logic [1:0] state_t;
  typedef logic       port_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ISSUE   = 2'd1;
  localparam state_t ST_CAPTURE = 2'd2;

  localparam port_t PORT0 = 1'b0;
  localparam port_t PORT1 = 1'b1;

endpackage

// File: rtl/rom_arb_if.sv
// Requester and ROM-side signals of the arbiter; slave = arbiter view, master = environment view.
interface rom_arb_if #(
  parameter int AW = 14,
  parameter int DW = 8
);
  logic          req0;
  logic          req1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic          ack0;
  logic          ack1;
  logic          valid0;
  logic          valid1;
  logic [DW-1:0] data0;
  logic [DW-1:0] data1;
  logic          rom_enable;
  logic [AW-1:0] rom_address;
  logic [DW-1:0] rom_q;
  logic          busy;

  modport slave (
    input  req0, req1, addr0, addr1, rom_q,
    output ack0, ack1, valid0, valid1, data0, data1, rom_enable, rom_address, busy
  );

  modport master (
    output req0, req1, addr0, addr1, rom_q,
    input  ack0, ack1, valid0, valid1, data0, data1, rom_enable, rom_address, busy
  );
endinterface

// File: rtl/rom_arb_pick.sv
// Combinational 2-way picker: ptr_i names the port that wins a tie when rr_i is set,
// otherwise port 0 always wins a tie.
module rom_arb_pick
  import rom_arb_pkg::*;
(
  input  logic  req0_i,
  input  logic  req1_i,
  input  port_t ptr_i,
  input  logic  rr_i,
  output port_t win_o
);

  always_comb begin
    win_o = PORT0;
    if (req0_i && req1_i) begin
      win_o = rr_i ? ptr_i : PORT0;
    end else if (req1_i) begin
      win_o = PORT1;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Two-port arbiter onto a 1-cycle synchronous ROM: ack at T+1, valid/data at T+3, one access per 3 cycles.
// Requesters hold req/addr until ack; requests are only sampled while IDLE.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int AW = 14,
  parameter int DW = 8,
  parameter int RR = 1
) (
  input  logic      clock,
  input  logic      reset,
  rom_arb_if.slave  bus
);

  state_t        state_q, state_d;
  port_t         ptr_q, ptr_d;
  port_t         win_q, win_d;
  port_t         pick;
  logic [AW-1:0] rom_address_q, rom_address_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  logic          valid0_q, valid0_d, valid1_q, valid1_d;
  logic [DW-1:0] data0_q, data0_d, data1_q, data1_d;

  rom_arb_pick u_pick (
    .req0_i (bus.req0),
    .req1_i (bus.req1),
    .ptr_i  (ptr_q),
    .rr_i   (RR != 0),
    .win_o  (pick)
  );

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    win_d         = win_q;
    rom_address_d = rom_address_q;
    ack0_d        = 1'b0;
    ack1_d        = 1'b0;
    valid0_d      = 1'b0;
    valid1_d      = 1'b0;
    data0_d       = data0_q;
    data1_d       = data1_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req0 || bus.req1) begin
          rom_address_d = (pick == PORT1) ? bus.addr1 : bus.addr0;
          ack0_d        = (pick == PORT0);
          ack1_d        = (pick == PORT1);
          win_d         = pick;
          // Pointer moves only on a grant: the loser gets the next tie.
          ptr_d         = ~pick;
          state_d       = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_d = ST_IDLE;
        if (win_q == PORT0) begin
          valid0_d = 1'b1;
          data0_d  = bus.rom_q;
        end else begin
          valid1_d = 1'b1;
          data1_d  = bus.rom_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      ptr_q         <= PORT0;
      win_q         <= PORT0;
      rom_address_q <= '0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      valid0_q      <= 1'b0;
      valid1_q      <= 1'b0;
      data0_q       <= '0;
      data1_q       <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      win_q         <= win_d;
      rom_address_q <= rom_address_d;
      ack0_q        <= ack0_d;
      ack1_q        <= ack1_d;
      valid0_q      <= valid0_d;
      valid1_q      <= valid1_d;
      data0_q       <= data0_d;
      data1_q       <= data1_d;
    end
  end

  assign bus.ack0        = ack0_q;
  assign bus.ack1        = ack1_q;
  assign bus.valid0      = valid0_q;
  assign bus.valid1      = valid1_q;
  assign bus.data0       = data0_q;
  assign bus.data1       = data1_q;
  assign bus.rom_enable  = (state_q == ST_ISSUE);
  assign bus.rom_address = rom_address_q;
  assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rom_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter with the same traffic profile and
// compares every output, every cycle, against a transaction-timeline model.
module tb_rom_arbiter;

  localparam int AW   = 14;
  localparam int DW   = 8;
  localparam int NCYC = 3000;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  rom_arb_if #(.AW(AW), .DW(DW)) bus_rr ();
  rom_arb_if #(.AW(AW), .DW(DW)) bus_fp ();

  rom_arbiter #(.AW(AW), .DW(DW), .RR(1)) dut_rr (.clock(clock), .reset(reset), .bus(bus_rr.slave));
  rom_arbiter #(.AW(AW), .DW(DW), .RR(0)) dut_fp (.clock(clock), .reset(reset), .bus(bus_fp.slave));

  // Synchronous ROM, one per arbiter, sharing contents.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (bus_rr.rom_enable) bus_rr.rom_q <= mem[bus_rr.rom_address];
    if (bus_fp.rom_enable) bus_fp.rom_q <= mem[bus_fp.rom_address];
  end

  // Index 0 = round-robin instance, 1 = fixed-priority instance.
  logic          req_d  [2][2];
  logic [AW-1:0] addr_d [2][2];
  assign bus_rr.req0  = req_d[0][0];
  assign bus_rr.req1  = req_d[0][1];
  assign bus_rr.addr0 = addr_d[0][0];
  assign bus_rr.addr1 = addr_d[0][1];
  assign bus_fp.req0  = req_d[1][0];
  assign bus_fp.req1  = req_d[1][1];
  assign bus_fp.addr0 = addr_d[1][0];
  assign bus_fp.addr1 = addr_d[1][1];

  logic [1:0]    o_ack  [2];
  logic [1:0]    o_val  [2];
  logic          o_en   [2];
  logic          o_busy [2];
  logic [AW-1:0] o_addr [2];
  logic [DW-1:0] o_dat  [2][2];
  assign o_ack[0]    = {bus_rr.ack1, bus_rr.ack0};
  assign o_ack[1]    = {bus_fp.ack1, bus_fp.ack0};
  assign o_val[0]    = {bus_rr.valid1, bus_rr.valid0};
  assign o_val[1]    = {bus_fp.valid1, bus_fp.valid0};
  assign o_en[0]     = bus_rr.rom_enable;
  assign o_en[1]     = bus_fp.rom_enable;
  assign o_busy[0]   = bus_rr.busy;
  assign o_busy[1]   = bus_fp.busy;
  assign o_addr[0]   = bus_rr.rom_address;
  assign o_addr[1]   = bus_fp.rom_address;
  assign o_dat[0][0] = bus_rr.data0;
  assign o_dat[0][1] = bus_rr.data1;
  assign o_dat[1][0] = bus_fp.data0;
  assign o_dat[1][1] = bus_fp.data1;

  // Model: a ring of per-cycle expectations scheduled when a grant is predicted.
  logic [1:0]    s_ack  [2][8];
  logic [1:0]    s_val  [2][8];
  logic          s_busy [2][8];
  logic          s_en   [2][8];
  logic          s_aset [2][8];
  logic          s_rst  [2][8];
  logic [AW-1:0] s_addr [2][8];
  logic [DW-1:0] s_dat  [2][8][2];
  logic [DW-1:0] cur_dat  [2][2];
  logic [AW-1:0] cur_addr [2];
  int            free_c [2];
  int            last_w [2];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clr_slot(input int k, input int s);
    s_ack[k][s]  = '0;
    s_val[k][s]  = '0;
    s_busy[k][s] = 1'b0;
    s_en[k][s]   = 1'b0;
    s_aset[k][s] = 1'b0;
    s_rst[k][s]  = 1'b0;
    s_addr[k][s] = '0;
    s_dat[k][s][0] = '0;
    s_dat[k][s][1] = '0;
  endtask

  task automatic check_cycle(input int k, input int n);
    int    s;
    string nm;
    s  = n % 8;
    nm = (k == 0) ? "rr" : "fp";
    if (s_rst[k][s]) begin
      cur_dat[k][0] = '0;
      cur_dat[k][1] = '0;
      cur_addr[k]   = '0;
    end
    if (s_aset[k][s]) cur_addr[k] = s_addr[k][s];
    for (int p = 0; p < 2; p++)
      if (s_val[k][s][p]) cur_dat[k][p] = s_dat[k][s][p];
    chk($sformatf("%s.ack", nm),      32'(o_ack[k]),    32'(s_ack[k][s]));
    chk($sformatf("%s.valid", nm),    32'(o_val[k]),    32'(s_val[k][s]));
    chk($sformatf("%s.data0", nm),    32'(o_dat[k][0]), 32'(cur_dat[k][0]));
    chk($sformatf("%s.data1", nm),    32'(o_dat[k][1]), 32'(cur_dat[k][1]));
    chk($sformatf("%s.rom_en", nm),   32'(o_en[k]),     32'(s_en[k][s]));
    chk($sformatf("%s.rom_addr", nm), 32'(o_addr[k]),   32'(cur_addr[k]));
    chk($sformatf("%s.busy", nm),     32'(o_busy[k]),   32'(s_busy[k][s]));
    clr_slot(k, s);
  endtask

  // Requests driven for cycle n are seen by the arbiter at the following edge.
  task automatic model_step(input int k, input int n, input logic rst);
    int            w;
    logic [AW-1:0] a;
    if (rst) begin
      for (int j = 1; j < 8; j++) clr_slot(k, (n + j) % 8);
      s_rst[k][(n + 1) % 8] = 1'b1;
      free_c[k] = n + 1;
      last_w[k] = 1;
    end else if (n >= free_c[k] && (req_d[k][0] || req_d[k][1])) begin
      if (req_d[k][0] && req_d[k][1]) w = (k == 0) ? 1 - last_w[k] : 0;
      else                            w = req_d[k][0] ? 0 : 1;
      a = addr_d[k][w];
      s_ack[k][(n + 1) % 8][w]  = 1'b1;
      s_busy[k][(n + 1) % 8]    = 1'b1;
      s_en[k][(n + 1) % 8]      = 1'b1;
      s_aset[k][(n + 1) % 8]    = 1'b1;
      s_addr[k][(n + 1) % 8]    = a;
      s_busy[k][(n + 2) % 8]    = 1'b1;
      s_val[k][(n + 3) % 8][w]  = 1'b1;
      s_dat[k][(n + 3) % 8][w]  = mem[a];
      free_c[k] = n + 3;
      last_w[k] = w;
    end
  endtask

  function automatic logic [AW-1:0] pick_addr(input logic fixed, input logic [AW-1:0] faddr);
    int r;
    if (fixed) return faddr;
    r = int'($urandom_range(7));
    if (r == 0) return '1;
    if (r == 1) return '0;
    return AW'($urandom);
  endfunction

  // A requester keeps req and addr stable until it sees its ack.
  task automatic drive_port(input int k, input int p, input int raise_pct, input int keep_pct,
                            input logic fixed, input logic [AW-1:0] faddr);
    if (req_d[k][p]) begin
      if (o_ack[k][p]) begin
        if (int'($urandom_range(99)) < keep_pct) addr_d[k][p] = pick_addr(fixed, faddr);
        else                                     req_d[k][p]  = 1'b0;
      end
    end else if (int'($urandom_range(99)) < raise_pct) begin
      req_d[k][p]  = 1'b1;
      addr_d[k][p] = pick_addr(fixed, faddr);
    end
  endtask

  initial begin
    logic          rst_now, rst_next, arm, fx;
    int            rp0, rp1, kp0, kp1;
    logic [AW-1:0] fa0, fa1;

    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    mem[14'h0010] = 8'hA5;
    mem[14'h3FFF] = 8'h5A;

    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        req_d[k][p]   = 1'b0;
        addr_d[k][p]  = '0;
        cur_dat[k][p] = '0;
      end
      cur_addr[k] = '0;
      free_c[k]   = 0;
      last_w[k]   = 1;
      for (int s = 0; s < 8; s++) clr_slot(k, s);
    end
    rst_next = 1'b0;
    arm      = 1'b0;

    for (int n = 0; n < NCYC; n++) begin
      @(negedge clock);
      check_cycle(0, n);
      check_cycle(1, n);

      if (n < 13) begin
        rp0 = 100; kp0 = 0;   rp1 = 0;   kp1 = 0;   fx = 1'b1; fa0 = 14'h0010; fa1 = 14'h0000;
      end else if (n < 41) begin
        rp0 = 100; kp0 = 100; rp1 = 100; kp1 = 100; fx = 1'b1; fa0 = 14'h0001; fa1 = 14'h0002;
      end else if (n < 53) begin
        rp0 = 0;   kp0 = 0;   rp1 = 100; kp1 = 0;   fx = 1'b1; fa0 = 14'h0000; fa1 = 14'h3FFF;
      end else begin
        rp0 = 40;  kp0 = 50;  rp1 = 40;  kp1 = 50;  fx = 1'b0; fa0 = 14'h0000; fa1 = 14'h0000;
      end

      rst_now  = (n < 3) || rst_next || (n >= 53 && int'($urandom_range(99)) == 0);
      rst_next = 1'b0;
      // One directed abort: reset lands in the cycle after an ack, i.e. during CAPTURE.
      if (n == 30) arm = 1'b1;
      if (arm && o_ack[0][0]) begin
        rst_next = 1'b1;
        arm      = 1'b0;
      end
      reset = rst_now;

      for (int k = 0; k < 2; k++) begin
        drive_port(k, 0, rp0, kp0, fx, fa0);
        drive_port(k, 1, rp1, kp1, fx, fa1);
      end
      model_step(0, n, rst_now);
      model_step(1, n, rst_now);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
